// File: rtl/mp64_mul_ctrl.sv
// Multiply-unit front end: issues ops to a 64x64->128 multiplier,
// applies the MULHSU correction and caches the last unsigned/signed product.
module mp64_mul_ctrl #(
    parameter bit REUSE = 1'b1,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [63:0]      req_a,
    input  logic [63:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             mul_start,
    output logic             mul_signed,
    output logic [63:0]      mul_a,
    output logic [63:0]      mul_b,
    input  logic [127:0]     mul_result,
    input  logic             mul_done
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FIX,
        RESP,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic [1:0]       op_q;
    logic [63:0]      a_q;
    logic [63:0]      b_q;
    logic [TAG_W-1:0] tag_q;
    logic             mode_q;
    logic [127:0]     prod_q;

    logic             cache_v;
    logic [63:0]      cache_a;
    logic [63:0]      cache_b;
    logic             cache_mode;
    logic [127:0]     cache_p;

    logic accept;
    logic mode_in;
    logic hit;
    logic is_hsu_q;
    logic wait_done;

    assign req_ready = (state == IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign mode_in   = (req_op == 2'b01);
    assign hit       = REUSE && cache_v && (req_a == cache_a) &&
                       (req_b == cache_b) && (mode_in == cache_mode);
    assign is_hsu_q  = (op_q == 2'b10);
    assign wait_done = (state == WAIT) && mul_done && !flush;

    assign rsp_data = (op_q == 2'b00) ? prod_q[63:0] : prod_q[127:64];
    assign rsp_tag  = tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        mul_start  = 1'b0;
        mul_signed = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        state_n = (req_op == 2'b10) ? FIX : RESP;
                    end else begin
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mul_start  = 1'b1;
                mul_signed = mode_q;
                state_n    = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    state_n = is_hsu_q ? FIX : RESP;
                end
            end
            FIX: begin
                state_n = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            DRAIN: begin
                if (mul_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A start already issued must have its done absorbed before reuse.
        if (flush) begin
            unique case (state)
                ISSUE:   state_n = DRAIN;
                WAIT:    state_n = mul_done ? IDLE : DRAIN;
                DRAIN:   state_n = mul_done ? IDLE : DRAIN;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 2'b00;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            mode_q     <= 1'b0;
            prod_q     <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            cache_v    <= 1'b0;
            cache_a    <= '0;
            cache_b    <= '0;
            cache_mode <= 1'b0;
            cache_p    <= '0;
        end else begin
            if (accept) begin
                op_q   <= req_op;
                a_q    <= req_a;
                b_q    <= req_b;
                tag_q  <= req_tag;
                mode_q <= mode_in;
                if (hit) begin
                    prod_q <= cache_p;
                end else begin
                    mul_a <= req_a;
                    mul_b <= req_b;
                end
            end
            if (wait_done) begin
                prod_q     <= mul_result;
                cache_v    <= 1'b1;
                cache_a    <= a_q;
                cache_b    <= b_q;
                cache_mode <= mode_q;
                cache_p    <= mul_result;
            end
            // Signed-a correction of an unsigned product; cache stays unsigned.
            if (state == FIX) begin
                prod_q[127:64] <= prod_q[127:64] - (a_q[63] ? b_q : 64'd0);
            end
            if (flush) begin
                cache_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mp64_mul_ctrl.sv
// Bench for mp64_mul_ctrl: directed plan steps plus random ops checked
// against an arithmetic reference and a rule-level cache model.
module tb_mp64_mul_ctrl;

    localparam int L = 4;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [63:0]      req_a = '0;
    logic [63:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [63:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             mul_start;
    logic             mul_signed;
    logic [63:0]      mul_a;
    logic [63:0]      mul_b;
    logic [127:0]     mul_result = '0;
    logic             mul_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int n_done = 0;
    logic last_signed = 1'b0;
    int mcnt = 0;
    logic [127:0] mpend = '0;

    bit          m_cv = 0;
    logic [63:0] m_a = '0;
    logic [63:0] m_b = '0;
    bit          m_mode = 0;
    logic [63:0] exp_ma = '0;
    logic [63:0] exp_mb = '0;

    mp64_mul_ctrl #(.REUSE(1'b1), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_tag    (rsp_tag),
        .mul_start  (mul_start),
        .mul_signed (mul_signed),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] prod128(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic sa,
                                             input logic sb);
        logic [127:0] xa;
        logic [127:0] xb;
        xa = sa ? {{64{a[63]}}, a} : {64'd0, a};
        xb = sb ? {{64{b[63]}}, b} : {64'd0, b};
        return xa * xb;
    endfunction

    function automatic logic [63:0] ref_result(input logic [1:0] op,
                                               input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] p;
        case (op)
            2'b00:   p = prod128(a, b, 1'b0, 1'b0);
            2'b01:   p = prod128(a, b, 1'b1, 1'b1);
            2'b10:   p = prod128(a, b, 1'b1, 1'b0);
            default: p = prod128(a, b, 1'b0, 1'b0);
        endcase
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    // Multiplier primitive: fixed latency L from start to done.
    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (rst) begin
            mcnt <= 0;
        end else begin
            if (mcnt == 1) begin
                mul_done   <= 1'b1;
                mul_result <= mpend;
            end
            if (mcnt != 0) mcnt <= mcnt - 1;
            if (mul_start) begin
                mcnt  <= L - 1;
                mpend <= prod128(mul_a, mul_b, mul_signed, mul_signed);
            end
        end
    end

    always @(posedge clk) begin
        if (mul_start) begin
            n_start     <= n_start + 1;
            last_signed <= mul_signed;
        end
        if (mul_done) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({p, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({p, "_rsp_data"}, rsp_data, 64'd0);
        chk({p, "_rsp_tag"}, 64'(rsp_tag), 64'd0);
        chk({p, "_mul_start"}, 64'(mul_start), 64'd0);
        chk({p, "_mul_signed"}, 64'(mul_signed), 64'd0);
        chk({p, "_mul_a"}, mul_a, 64'd0);
        chk({p, "_mul_b"}, mul_b, 64'd0);
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_op(input string nm, input logic [1:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tag, input int hold);
        logic [63:0] expd;
        bit hit;
        bit hsu;
        int lat_exp;
        int k;
        int s0;
        hit = m_cv && (a == m_a) && (b == m_b) && ((op == 2'b01) == m_mode);
        hsu = (op == 2'b10);
        lat_exp = hit ? (hsu ? 2 : 1) : (hsu ? 3 + L : 2 + L);
        expd = ref_result(op, a, b);
        if (!hit) begin
            m_cv = 1;
            m_a = a;
            m_b = b;
            m_mode = (op == 2'b01);
            exp_ma = a;
            exp_mb = b;
        end
        wait_ready();
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_tag = tag;
        s0 = n_start;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_latency"}, 64'(k), 64'(lat_exp));
        chk({nm, "_data"}, rsp_data, expd);
        chk({nm, "_tag"}, 64'(rsp_tag), 64'(tag));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({nm, "_hold_data"}, rsp_data, expd);
            chk({nm, "_hold_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_ready_after"}, 64'(req_ready), 64'd1);
        chk({nm, "_starts"}, 64'(n_start - s0), hit ? 64'd0 : 64'd1);
        if (!hit) chk({nm, "_signed"}, 64'(last_signed), 64'(op == 2'b01));
        chk({nm, "_mul_a"}, mul_a, exp_ma);
        chk({nm, "_mul_b"}, mul_b, exp_mb);
    endtask

    initial begin
        logic [63:0] ones;
        logic [63:0] ra;
        logic [63:0] rb;
        int k;
        int s0;
        int d0;
        bit seen_v;
        ones = '1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");

        do_op("mul_3x5", 2'b00, 64'd3, 64'd5, 5'h1A, 0);
        do_op("mulh_neg1x2", 2'b01, ones, 64'd2, 5'h02, 0);
        do_op("mulhsu_neg1x2", 2'b10, ones, 64'd2, 5'h03, 0);
        do_op("mulhu_hit", 2'b11, ones, 64'd2, 5'h04, 0);
        do_op("mul_hit", 2'b00, ones, 64'd2, 5'h05, 0);
        do_op("mulhsu_hit", 2'b10, ones, 64'd2, 5'h06, 0);

        // flush two cycles after mul_start
        wait_ready();
        req_valid = 1'b1;
        req_op = 2'b11;
        req_a = 64'd7;
        req_b = 64'd9;
        req_tag = 5'h07;
        s0 = n_start;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("flush_start_pulse", 64'(mul_start), 64'd1);
        d0 = n_done;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        chk("flush_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        m_cv = 0;
        exp_ma = 64'd7;
        exp_mb = 64'd9;
        k = 4;
        seen_v = 0;
        while (!req_ready && k < 40) begin
            if (rsp_valid) seen_v = 1;
            @(negedge clk);
            k++;
        end
        chk("flush_ready_cycle", 64'(k), 64'd6);
        chk("flush_no_rsp", 64'(seen_v), 64'd0);
        chk("flush_done_seen", 64'(n_done - d0), 64'd1);
        chk("flush_one_start", 64'(n_start - s0), 64'd1);
        do_op("after_flush_miss", 2'b11, 64'd7, 64'd9, 5'h08, 0);
        do_op("after_flush_inval", 2'b11, ones, 64'd2, 5'h09, 0);

        do_op("hold3", 2'b01, 64'h8000_0000_0000_0001, 64'h7FFF_0000_1234_5678,
              5'h0A, 3);

        // rst while waiting on the multiplier
        wait_ready();
        req_valid = 1'b1;
        req_op = 2'b00;
        req_a = 64'd11;
        req_b = 64'd13;
        req_tag = 5'h0B;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid_wait");
        rst = 1'b0;
        m_cv = 0;
        exp_ma = '0;
        exp_mb = '0;
        @(negedge clk);
        do_op("after_rst", 2'b00, 64'd11, 64'd13, 5'h0C, 1);

        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) ra = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) rb = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) ra = ones;
            do_op("rand", 2'($urandom_range(0, 3)), ra, rb,
                  TAG_W'($urandom_range(0, 31)), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
